// File: rtl/wm_blink_timer.sv
// Phase timer for one washer phase: counts a loaded number of seconds in half-second
// slots and drives the blink strobe, slot index and phase status to neighbouring stages.
`default_nettype none

module wm_blink_timer #(
  parameter int HALF_SEC_CYCLES = 62500000,
  parameter int BLINK_PERIOD    = 2,
  parameter int SEC_W           = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             pause,
  input  logic             abort,
  input  logic [SEC_W-1:0] load_sec,
  output logic             ledEn,
  output logic             clkCnt_0p5secEnd,
  output logic [7:0]       cnt,
  output logic [SEC_W-1:0] remain_sec,
  output logic             busy,
  output logic             done
);

  localparam int PW = (HALF_SEC_CYCLES > 1) ? $clog2(HALF_SEC_CYCLES) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(HALF_SEC_CYCLES - 1);
  localparam logic [7:0]    CNT_MAX   = 8'(BLINK_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state, state_nx;
  logic [PW-1:0]    presc, presc_nx;
  logic             half, half_nx;
  logic [7:0]       cnt_nx;
  logic [SEC_W-1:0] remain_nx;
  logic             strobe_nx;
  logic             load_ok;
  logic             finish_now;

  assign load_ok = start && !pause && (load_sec != '0);

  always_comb begin
    state_nx   = state;
    presc_nx   = presc;
    half_nx    = half;
    cnt_nx     = cnt;
    remain_nx  = remain_sec;
    strobe_nx  = 1'b0;
    finish_now = 1'b0;

    case (state)
      IDLE, DONE: begin
        if (load_ok) begin
          state_nx  = RUN;
          remain_nx = load_sec;
          presc_nx  = '0;
          cnt_nx    = 8'd0;
          half_nx   = 1'b0;
        end
      end

      RUN: begin
        // The strobe is live for this edge: close out the slot it marks.
        if (clkCnt_0p5secEnd) begin
          cnt_nx  = (cnt == CNT_MAX) ? 8'd0 : cnt + 8'd1;
          half_nx = ~half;
          if (half) begin
            remain_nx  = remain_sec - SEC_W'(1);
            finish_now = (remain_sec == SEC_W'(1));
          end
        end
        if (pause) begin
          state_nx = PAUSE;
        end else begin
          presc_nx  = (presc == PRESC_MAX) ? '0 : presc + PW'(1);
          strobe_nx = (presc == PRESC_MAX);
        end
        if (finish_now) begin
          state_nx  = DONE;
          presc_nx  = '0;
          cnt_nx    = 8'd0;
          half_nx   = 1'b0;
          remain_nx = '0;
          strobe_nx = 1'b0;
        end
      end

      PAUSE: begin
        if (start && !pause) begin
          state_nx = RUN;
        end
      end

      default: state_nx = IDLE;
    endcase

    if (abort) begin
      state_nx  = IDLE;
      presc_nx  = '0;
      half_nx   = 1'b0;
      cnt_nx    = 8'd0;
      remain_nx = '0;
      strobe_nx = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      presc            <= '0;
      half             <= 1'b0;
      cnt              <= 8'd0;
      remain_sec       <= '0;
      clkCnt_0p5secEnd <= 1'b0;
      ledEn            <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
    end else begin
      state            <= state_nx;
      presc            <= presc_nx;
      half             <= half_nx;
      cnt              <= cnt_nx;
      remain_sec       <= remain_nx;
      clkCnt_0p5secEnd <= strobe_nx;
      ledEn            <= (state_nx == RUN);
      busy             <= (state_nx == RUN) || (state_nx == PAUSE);
      done             <= (state_nx == DONE);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_wm_blink_timer.sv
// Directed bench for wm_blink_timer with a 4-cycle half-second.
`default_nettype none

module tb_wm_blink_timer;

  localparam int H  = 4;
  localparam int SW = 12;

  logic          clk = 1'b0;
  logic          rst, start, pause, abort;
  logic [SW-1:0] load_sec;
  logic          ledEn, strobe, busy, done;
  logic [7:0]    cnt;
  logic [SW-1:0] remain_sec;

  int checks = 0;
  int errors = 0;

  wm_blink_timer #(.HALF_SEC_CYCLES(H), .BLINK_PERIOD(2), .SEC_W(SW)) dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .abort(abort),
    .load_sec(load_sec), .ledEn(ledEn), .clkCnt_0p5secEnd(strobe), .cnt(cnt),
    .remain_sec(remain_sec), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic pulse_start(input int secs);
    load_sec = SW'(secs);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; pause = 1'b0; abort = 1'b0; load_sec = '0;
    step(); step();
    checks++;
    if ({ledEn, strobe, busy, done} !== 4'b0000 || cnt !== 8'd0 || remain_sec !== '0) begin
      errors++;
      $display("FAIL reset: led/strb/busy/done=%b cnt=%0d remain=%0d, need 0000 0 0",
               {ledEn, strobe, busy, done}, cnt, remain_sec);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic_run();
    int n = 0;
    int er;
    logic es, ed;
    pulse_start(3);
    checks++;
    if (ledEn !== 1'b1 || busy !== 1'b1 || remain_sec !== 12'd3) begin
      errors++;
      $display("FAIL basic_start: ledEn=%b busy=%b remain=%0d, need 1 1 3", ledEn, busy, remain_sec);
    end
    for (int k = 1; k <= 32; k++) begin
      step();
      es = (k % 4 == 0) && (k <= 24);
      er = (k < 9) ? 3 : (k < 17) ? 2 : (k < 25) ? 1 : 0;
      ed = (k >= 25);
      checks++;
      if (strobe !== es) begin
        errors++;
        $display("FAIL basic_strobe k=%0d: got %b, need %b", k, strobe, es);
      end
      if (strobe === 1'b1) begin
        n++;
        checks++;
        if (cnt !== 8'((n - 1) % 2)) begin
          errors++;
          $display("FAIL basic_cnt strobe %0d: got %0d, need %0d", n, cnt, (n - 1) % 2);
        end
      end
      checks++;
      if (remain_sec !== SW'(er) || done !== ed || ledEn !== !ed) begin
        errors++;
        $display("FAIL basic_state k=%0d: remain=%0d done=%b ledEn=%b, need %0d %b %b",
                 k, remain_sec, done, ledEn, er, ed, !ed);
      end
    end
    checks++;
    if (n != 6) begin
      errors++;
      $display("FAIL basic_count: got %0d strobes, need 6", n);
    end
  endtask

  task automatic test_pause_resume();
    int n = 0;
    logic es;
    pulse_start(2);
    for (int k = 1; k <= 6; k++) begin
      step();
      if (strobe === 1'b1) n++;
    end
    pause = 1'b1;
    step();
    pause = 1'b0;
    checks++;
    if (ledEn !== 1'b0 || busy !== 1'b1 || strobe !== 1'b0 || remain_sec !== 12'd2) begin
      errors++;
      $display("FAIL pause_enter: ledEn=%b busy=%b strobe=%b remain=%0d, need 0 1 0 2",
               ledEn, busy, strobe, remain_sec);
    end
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if (strobe !== 1'b0 || ledEn !== 1'b0 || remain_sec !== 12'd2) begin
        errors++;
        $display("FAIL pause_hold i=%0d: strobe=%b ledEn=%b remain=%0d, need 0 0 2",
                 i, strobe, ledEn, remain_sec);
      end
    end
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (ledEn !== 1'b1) begin
      errors++;
      $display("FAIL resume_led: got %b, need 1", ledEn);
    end
    for (int m = 1; m <= 12; m++) begin
      step();
      es = (m == 2) || (m == 6) || (m == 10);
      checks++;
      if (strobe !== es) begin
        errors++;
        $display("FAIL resume_strobe m=%0d: got %b, need %b", m, strobe, es);
      end
      if (strobe === 1'b1) n++;
      if (m == 2) begin
        checks++;
        if (cnt !== 8'd1 || remain_sec !== 12'd2) begin
          errors++;
          $display("FAIL resume_slot: cnt=%0d remain=%0d, need 1 2", cnt, remain_sec);
        end
      end
    end
    checks++;
    if (n != 4 || done !== 1'b1 || remain_sec !== '0) begin
      errors++;
      $display("FAIL pause_total: strobes=%0d done=%b remain=%0d, need 4 1 0", n, done, remain_sec);
    end
  endtask

  task automatic test_pause_on_strobe();
    pulse_start(2);
    for (int k = 1; k <= 8; k++) step();
    checks++;
    if (strobe !== 1'b1 || cnt !== 8'd1 || remain_sec !== 12'd2) begin
      errors++;
      $display("FAIL pstrobe_pre: strobe=%b cnt=%0d remain=%0d, need 1 1 2", strobe, cnt, remain_sec);
    end
    pause = 1'b1;
    step();
    pause = 1'b0;
    checks++;
    if (remain_sec !== 12'd1 || cnt !== 8'd0 || strobe !== 1'b0 || ledEn !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL pstrobe_edge: remain=%0d cnt=%0d strobe=%b ledEn=%b busy=%b, need 1 0 0 0 1",
               remain_sec, cnt, strobe, ledEn, busy);
    end
    step();
    checks++;
    if (strobe !== 1'b0 || remain_sec !== 12'd1) begin
      errors++;
      $display("FAIL pstrobe_hold: strobe=%b remain=%0d, need 0 1", strobe, remain_sec);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
  endtask

  task automatic test_abort();
    pulse_start(5);
    for (int k = 1; k <= 5; k++) step();
    checks++;
    if (cnt !== 8'd1 || remain_sec !== 12'd5) begin
      errors++;
      $display("FAIL abort_pre: cnt=%0d remain=%0d, need 1 5", cnt, remain_sec);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++;
    if ({ledEn, busy, strobe, done} !== 4'b0000 || remain_sec !== '0 || cnt !== 8'd0) begin
      errors++;
      $display("FAIL abort_run: led/busy/strb/done=%b remain=%0d cnt=%0d, need 0000 0 0",
               {ledEn, busy, strobe, done}, remain_sec, cnt);
    end
    abort = 1'b1;
    pulse_start(5);
    abort = 1'b0;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (busy !== 1'b0 || ledEn !== 1'b0 || strobe !== 1'b0 || remain_sec !== '0) begin
        errors++;
        $display("FAIL abort_start i=%0d: busy=%b ledEn=%b strobe=%b remain=%0d, need 0 0 0 0",
                 i, busy, ledEn, strobe, remain_sec);
      end
      step();
    end
  endtask

  task automatic test_zero_and_restart();
    int n = 0;
    pulse_start(0);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (busy !== 1'b0 || ledEn !== 1'b0 || strobe !== 1'b0) begin
        errors++;
        $display("FAIL zero_load i=%0d: busy=%b ledEn=%b strobe=%b, need 0 0 0", i, busy, ledEn, strobe);
      end
      step();
    end
    pulse_start(1);
    for (int k = 1; k <= 9; k++) step();
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL one_sec_done: done=%b busy=%b, need 1 0", done, busy);
    end
    pulse_start(1);
    checks++;
    if (ledEn !== 1'b1 || done !== 1'b0 || busy !== 1'b1 || remain_sec !== 12'd1) begin
      errors++;
      $display("FAIL restart: ledEn=%b done=%b busy=%b remain=%0d, need 1 0 1 1",
               ledEn, done, busy, remain_sec);
    end
    for (int k = 1; k <= 10; k++) begin
      step();
      if (strobe === 1'b1) n++;
      if (k == 9) begin
        checks++;
        if (done !== 1'b1 || ledEn !== 1'b0) begin
          errors++;
          $display("FAIL restart_done: done=%b ledEn=%b, need 1 0", done, ledEn);
        end
      end
    end
    checks++;
    if (n != 2) begin
      errors++;
      $display("FAIL restart_count: got %0d strobes, need 2", n);
    end
  endtask

  task automatic test_reset_mid_run();
    pulse_start(4);
    for (int k = 1; k <= 5; k++) step();
    checks++;
    if (cnt !== 8'd1 || remain_sec !== 12'd4) begin
      errors++;
      $display("FAIL rst_pre: cnt=%0d remain=%0d, need 1 4", cnt, remain_sec);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({ledEn, strobe, busy, done} !== 4'b0000 || cnt !== 8'd0 || remain_sec !== '0) begin
      errors++;
      $display("FAIL rst_mid: led/strb/busy/done=%b cnt=%0d remain=%0d, need 0000 0 0",
               {ledEn, strobe, busy, done}, cnt, remain_sec);
    end
    pulse_start(3);
    checks++;
    if (ledEn !== 1'b1 || remain_sec !== 12'd3 || cnt !== 8'd0) begin
      errors++;
      $display("FAIL rst_restart: ledEn=%b remain=%0d cnt=%0d, need 1 3 0", ledEn, remain_sec, cnt);
    end
    for (int k = 1; k <= 4; k++) begin
      step();
      checks++;
      if (strobe !== (k == 4)) begin
        errors++;
        $display("FAIL rst_strobe k=%0d: got %b, need %b", k, strobe, (k == 4));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_run();
    test_pause_resume();
    test_pause_on_strobe();
    test_abort();
    test_zero_and_restart();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/wm_blink_timer.md
Name: wm_blink_timer

Overview:
Phase timer for one washing-machine phase (wash/rinse/spin) that generates the blink-control stream for the downstream LED on/off stage. It is loaded with a duration in seconds and counts it down from a 125 MHz prescaler. It drives ledEn, a one-cycle 0.5 s end strobe, and a half-second index cnt that the LED stage samples on each strobe. It also reports remaining seconds, busy and done to the phase sequencer.

Parameters:
HALF_SEC_CYCLES, 62500000, clk cycles per 0.5 s (125 MHz / 2); minimum 2.
BLINK_PERIOD, 2, number of half-second slots in one blink cycle; cnt wraps at BLINK_PERIOD-1; range 2..256.
SEC_W, 12, width of the loaded and remaining second counts.

Ports:
clk  input  1  system clock, 125 MHz
rst  input  1  reset, synchronous, active-high
start  input  1  1-cycle pulse: begin a phase from IDLE/DONE, or resume from PAUSE
pause  input  1  1-cycle pulse: freeze a running phase
abort  input  1  1-cycle pulse: cancel and return to IDLE
load_sec  input  SEC_W  phase duration in seconds, sampled only when start is accepted from IDLE/DONE
ledEn  output  1  high only in RUN
clkCnt_0p5secEnd  output  1  1-cycle strobe at the end of each running half-second
cnt  output  8  index of the current half-second slot, 0..BLINK_PERIOD-1
remain_sec  output  SEC_W  seconds left in the phase
busy  output  1  high in RUN or PAUSE
done  output  1  high in DONE

Behaviour:
- All logic is on posedge clk. rst high: state=IDLE; ledEn, clkCnt_0p5secEnd, busy and done =0; cnt=0; remain_sec=0; prescaler=0; half flag=0. Reset mid-phase discards all progress.
- Command priority when pulses coincide: rst > abort > pause > start.
- IDLE:
  - start with load_sec!=0 -> RUN. On that edge: remain_sec<=load_sec; prescaler, cnt and half flag <=0.
  - start with load_sec==0 is ignored; state stays IDLE.
- RUN:
  - ledEn=1, busy=1. Prescaler increments every cycle.
  - At the edge where prescaler==HALF_SEC_CYCLES-1: prescaler<=0 and clkCnt_0p5secEnd<=1 for exactly one cycle. First strobe is high HALF_SEC_CYCLES cycles after the edge that accepted start; period is HALF_SEC_CYCLES.
  - While the strobe is high, cnt still holds the slot that is ending. The downstream stage sees cnt=0 then 1 on successive strobes.
  - On the edge where the strobe is high: cnt<=(cnt==BLINK_PERIOD-1)?0:cnt+1, and the half flag toggles.
  - If the half flag was 1 on that edge: remain_sec<=remain_sec-1. If remain_sec was 1, state<=DONE on the same edge.
  - start is ignored in RUN.
- PAUSE (from RUN on pause):
  - ledEn=0, busy=1. Prescaler, cnt, half flag and remain_sec are frozen; no strobes.
  - start resumes RUN from the frozen prescaler value.
  - pause is ignored.
  - If pause is sampled while the strobe is high, that strobe's cnt/half/remain updates still complete on that edge, and the strobe drops.
- DONE:
  - done=1, ledEn=0, busy=0, remain_sec=0, cnt=0, prescaler=0; no further strobes.
  - start with load_sec!=0 -> RUN with a fresh load. abort -> IDLE.
- abort in any state -> IDLE next edge: remain_sec=0, cnt=0, strobe=0.
- All outputs are registered. No combinational path from any input to any output.
- Prescaler width is clog2(HALF_SEC_CYCLES). remain_sec never underflows.

Test Plan:
1. HALF_SEC_CYCLES=4, load_sec=3, start pulse -> ledEn=1 on the next cycle; strobes every 4 cycles with cnt at strobe 0,1,0,1,0,1; remain_sec 3->2->1->0 after strobes 2/4/6; DONE (done=1, ledEn=0) on the cycle after strobe 6; exactly 6 strobes total.
2. load_sec=2, pause 6 cycles after start, hold 20 cycles, then start -> no strobes and ledEn=0 while paused; remain_sec frozen at 2; the second strobe arrives 2 cycles after resume (prescaler resumed at 2); phase completes with 4 strobes total.
3. Pause asserted in the same cycle as a strobe with half flag=1 and remain_sec=2 -> remain_sec becomes 1 and cnt advances on that edge; state=PAUSE; strobe lasts 1 cycle.
4. abort during RUN with remain_sec=5 -> next cycle IDLE; ledEn, busy, strobe=0; remain_sec=0, cnt=0. abort and start in the same cycle from IDLE -> stays IDLE.
5. start with load_sec=0 -> stays IDLE, busy=0, no strobes. From DONE, start with load_sec=1 -> RUN, done=0, two strobes, then DONE again.
6. rst asserted mid-RUN (cnt=1, remain_sec=4) -> next cycle all outputs 0 and state=IDLE; a later start behaves exactly as from power-up.
